// File: rtl/seq_controller.sv
// Multicycle sequencer for MIPS8: byte-wise fetch, memory-ready waits and vectored interrupt entry.
// All outputs decode combinationally from state; ie and irq_vec are the only registered outputs.
module seq_controller #(
  parameter int FETCH_BYTES = 2,
  parameter int N_IRQ       = 2,
  localparam int IDXW       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             op_class,
  input  logic                   br_taken,
  input  logic [N_IRQ-1:0]       irq,
  input  logic                   mem_rdy,
  output logic                   enPC,
  output logic [FETCH_BYTES-1:0] enIR,
  output logic                   enData,
  output logic                   enFlags,
  output logic                   we,
  output logic                   mem_we,
  output logic                   mem_re,
  output logic                   addr_src,
  output logic [1:0]             pc_src,
  output logic [1:0]             reg_src,
  output logic                   reg_dst,
  output logic [N_IRQ-1:0]       irq_ack,
  output logic [IDXW-1:0]        irq_vec,
  output logic                   ie
);

  localparam int CNTW = (FETCH_BYTES > 1) ? $clog2(FETCH_BYTES) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(FETCH_BYTES - 1);

  localparam logic [2:0] OP_ALU    = 3'd0;
  localparam logic [2:0] OP_CMP    = 3'd1;
  localparam logic [2:0] OP_BRANCH = 3'd2;
  localparam logic [2:0] OP_LOAD   = 3'd3;
  localparam logic [2:0] OP_STORE  = 3'd4;
  localparam logic [2:0] OP_MOV    = 3'd5;
  localparam logic [2:0] OP_RETI   = 3'd6;
  localparam logic [2:0] OP_EI     = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_IRQ_SAVE, S_IRQ_VEC
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ie_q, ie_d;
  logic [IDXW-1:0] irq_vec_q, irq_vec_d;
  logic [IDXW-1:0] irq_sel;
  logic            instr_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      ie_q      <= 1'b0;
      irq_vec_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ie_q      <= ie_d;
      irq_vec_q <= irq_vec_d;
    end
  end

  // Lowest-numbered pending request wins.
  always_comb begin
    irq_sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (irq[i]) irq_sel = IDXW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ie_d      = ie_q;
    irq_vec_d = irq_vec_q;
    instr_end = 1'b0;
    enPC      = 1'b0;
    enIR      = '0;
    enData    = 1'b0;
    enFlags   = 1'b0;
    we        = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    addr_src  = 1'b0;
    pc_src    = 2'd0;
    reg_src   = 2'd0;
    reg_dst   = 1'b0;
    irq_ack   = '0;

    case (state_q)
      S_FETCH: begin
        mem_re = 1'b1;
        if (mem_rdy) begin
          enIR = FETCH_BYTES'(1) << cnt_q;
          enPC = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_DECODE;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      S_DECODE: begin
        state_d = (op_class == OP_LOAD || op_class == OP_STORE) ? S_MEM : S_EXEC;
      end
      S_EXEC: begin
        case (op_class)
          OP_ALU: begin
            enFlags = 1'b1;
            state_d = S_WB;
          end
          OP_CMP: begin
            enFlags   = 1'b1;
            instr_end = 1'b1;
          end
          OP_BRANCH: begin
            enPC      = br_taken;
            pc_src    = 2'd1;
            instr_end = 1'b1;
          end
          OP_MOV: begin
            we        = 1'b1;
            reg_src   = 2'd2;
            instr_end = 1'b1;
          end
          OP_RETI: begin
            enPC      = 1'b1;
            pc_src    = 2'd3;
            ie_d      = 1'b1;
            instr_end = 1'b1;
          end
          OP_EI: begin
            ie_d      = 1'b1;
            instr_end = 1'b1;
          end
          default: instr_end = 1'b1;
        endcase
      end
      S_MEM: begin
        if (op_class == OP_LOAD) begin
          mem_re   = 1'b1;
          addr_src = 1'b1;
          if (mem_rdy) begin
            enData  = 1'b1;
            state_d = S_WB;
          end
        end else if (op_class == OP_STORE) begin
          mem_we   = 1'b1;
          addr_src = 1'b1;
          if (mem_rdy) instr_end = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        we        = 1'b1;
        reg_src   = (op_class == OP_LOAD) ? 2'd1 : 2'd0;
        instr_end = 1'b1;
      end
      S_IRQ_SAVE: begin
        we      = 1'b1;
        reg_dst = 1'b1;
        reg_src = 2'd3;
        state_d = S_IRQ_VEC;
      end
      S_IRQ_VEC: begin
        enPC    = 1'b1;
        pc_src  = 2'd2;
        irq_ack = N_IRQ'(1) << irq_vec_q;
        ie_d    = 1'b0;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // ie_d rather than ie_q so RETI/EI can take a pending interrupt at their own end.
    if (instr_end) begin
      if (ie_d && (|irq)) begin
        state_d   = S_IRQ_SAVE;
        irq_vec_d = irq_sel;
      end else begin
        state_d = S_FETCH;
      end
    end
  end

  assign ie      = ie_q;
  assign irq_vec = irq_vec_q;

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller (FETCH_BYTES=2, N_IRQ=4): stimulus pushes expected
// per-cycle output vectors into a queue, a negedge monitor pops and compares them.
module tb_seq_controller;

  typedef struct packed {
    logic       enPC;
    logic [1:0] enIR;
    logic       enData;
    logic       enFlags;
    logic       we;
    logic       mem_we;
    logic       mem_re;
    logic       addr_src;
    logic [1:0] pc_src;
    logic [1:0] reg_src;
    logic       reg_dst;
    logic [3:0] irq_ack;
    logic [1:0] irq_vec;
    logic       ie;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] op_class;
  logic       br_taken;
  logic [3:0] irq;
  logic       mem_rdy;
  logic       enPC, enData, enFlags, we, mem_we, mem_re, addr_src, reg_dst, ie;
  logic [1:0] enIR, pc_src, reg_src, irq_vec;
  logic [3:0] irq_ack;

  exp_t  got;
  exp_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  m_ie;
  logic [1:0] m_vec;

  seq_controller #(.FETCH_BYTES(2), .N_IRQ(4)) dut (
    .clk(clk), .rst(rst), .op_class(op_class), .br_taken(br_taken), .irq(irq),
    .mem_rdy(mem_rdy), .enPC(enPC), .enIR(enIR), .enData(enData), .enFlags(enFlags),
    .we(we), .mem_we(mem_we), .mem_re(mem_re), .addr_src(addr_src), .pc_src(pc_src),
    .reg_src(reg_src), .reg_dst(reg_dst), .irq_ack(irq_ack), .irq_vec(irq_vec), .ie(ie)
  );

  always #5 clk = ~clk;

  assign got = {enPC, enIR, enData, enFlags, we, mem_we, mem_re, addr_src,
                pc_src, reg_src, reg_dst, irq_ack, irq_vec, ie};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s: got %h required %h", t, got, e);
      end
    end
  end

  function automatic exp_t x0();
    exp_t e;
    e = '0;
    e.ie = m_ie;
    e.irq_vec = m_vec;
    return e;
  endfunction

  task automatic step(input string tag, input exp_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_byte(input string tag, input int b, input logic rdy);
    exp_t e;
    mem_rdy = rdy;
    e = x0();
    e.mem_re = 1'b1;
    if (rdy) begin
      e.enIR = 2'(1 << b);
      e.enPC = 1'b1;
    end
    step(tag, e);
  endtask

  task automatic fetch_decode(input string tag);
    fetch_byte(tag, 0, 1'b1);
    fetch_byte(tag, 1, 1'b1);
    step({tag, "_dec"}, x0());
  endtask

  initial begin
    exp_t e;
    rst = 1'b0; mem_rdy = 1'b0; op_class = 3'd0; br_taken = 1'b0; irq = 4'b0000;
    m_ie = 1'b0; m_vec = 2'd0;
    @(posedge clk);
    #1;
    e = x0(); e.mem_re = 1'b1;
    step("reset", e);
    step("reset", e);
    rst = 1'b1;

    // ALU, 5-cycle instruction
    op_class = 3'd0;
    fetch_decode("alu");
    e = x0(); e.enFlags = 1'b1; step("alu_exec", e);
    e = x0(); e.we = 1'b1; step("alu_wb", e);

    // CMP with 3 wait cycles on the second fetch byte
    op_class = 3'd1;
    fetch_byte("wait_b0", 0, 1'b1);
    repeat (3) fetch_byte("wait_stall", 1, 1'b0);
    fetch_byte("wait_b1", 1, 1'b1);
    step("cmp_dec", x0());
    e = x0(); e.enFlags = 1'b1; step("cmp_exec", e);

    // LOAD with 2 wait cycles in MEM
    op_class = 3'd3;
    fetch_decode("load");
    mem_rdy = 1'b0;
    e = x0(); e.mem_re = 1'b1; e.addr_src = 1'b1;
    step("load_wait", e);
    step("load_wait", e);
    mem_rdy = 1'b1;
    e.enData = 1'b1;
    step("load_rdy", e);
    e = x0(); e.we = 1'b1; e.reg_src = 2'd1; step("load_wb", e);

    // BRANCH not taken, then taken
    op_class = 3'd2; br_taken = 1'b0;
    fetch_decode("br_nt");
    e = x0(); e.pc_src = 2'd1; step("br_nt_exec", e);
    br_taken = 1'b1;
    fetch_decode("br_t");
    e = x0(); e.pc_src = 2'd1; e.enPC = 1'b1; step("br_t_exec", e);
    br_taken = 1'b0;

    // MOV
    op_class = 3'd5;
    fetch_decode("mov");
    e = x0(); e.we = 1'b1; e.reg_src = 2'd2; step("mov_exec", e);

    // STORE with one wait cycle
    op_class = 3'd4;
    fetch_decode("store");
    mem_rdy = 1'b0;
    e = x0(); e.mem_we = 1'b1; e.addr_src = 1'b1;
    step("store_wait", e);
    mem_rdy = 1'b1;
    step("store_rdy", e);

    // EI, then ALU with irq=0110 -> vector 1
    op_class = 3'd7;
    fetch_decode("ei");
    step("ei_exec", x0());
    m_ie = 1'b1;
    irq = 4'b0110; op_class = 3'd0;
    fetch_decode("irq_alu");
    e = x0(); e.enFlags = 1'b1; step("irq_alu_exec", e);
    e = x0(); e.we = 1'b1; step("irq_alu_wb", e);
    m_vec = 2'd1;
    irq = 4'b0111;
    e = x0(); e.we = 1'b1; e.reg_dst = 1'b1; e.reg_src = 2'd3; step("irq_save", e);
    irq = 4'b0110;
    e = x0(); e.enPC = 1'b1; e.pc_src = 2'd2; e.irq_ack = 4'b0010; step("irq_vec", e);
    m_ie = 1'b0;

    // Held irq with ie=0: no re-entry
    op_class = 3'd0;
    fetch_decode("hold_alu");
    e = x0(); e.enFlags = 1'b1; step("hold_alu_exec", e);
    e = x0(); e.we = 1'b1; step("hold_alu_wb", e);

    // RETI with pending irq: immediate re-entry; request dropped after sampling
    op_class = 3'd6;
    fetch_decode("reti");
    e = x0(); e.enPC = 1'b1; e.pc_src = 2'd3; step("reti_exec", e);
    m_ie = 1'b1;
    irq = 4'b0000;
    e = x0(); e.we = 1'b1; e.reg_dst = 1'b1; e.reg_src = 2'd3; step("reti_save", e);
    e = x0(); e.enPC = 1'b1; e.pc_src = 2'd2; e.irq_ack = 4'b0010; step("reti_vec", e);
    m_ie = 1'b0;

    // Reset in the middle of a stalled STORE
    op_class = 3'd7;
    fetch_decode("ei2");
    step("ei2_exec", x0());
    m_ie = 1'b1;
    op_class = 3'd4;
    fetch_decode("rst_store");
    mem_rdy = 1'b0;
    e = x0(); e.mem_we = 1'b1; e.addr_src = 1'b1; step("rst_store_wait", e);
    rst = 1'b0;
    m_ie = 1'b0; m_vec = 2'd0;
    e = x0(); e.mem_re = 1'b1; step("rst_mid_store", e);
    rst = 1'b1; op_class = 3'd0;
    fetch_byte("restart_b0", 0, 1'b1);
    fetch_byte("restart_b1", 1, 1'b1);
    step("restart_dec", x0());

    repeat (2) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
